// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the cacheline memory arbiter
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_LINE_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH = 32;

  // Port index width; never below one bit so two-port builds still get a real index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational one-hot winner select, rotating or fixed priority
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int FIXED_PRIO = 0,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_req
);

  int             cand;
  logic [IDX_W-1:0] cand_idx;
  logic           found;

  // Walk ports starting at ptr (or at 0 in fixed mode); first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (FIXED_PRIO != 0) ? i : int'(ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/multi_port_arbiter.sv
// rtl/multi_port_arbiter.sv - arbitrates per-port cacheline read/write requests onto one memory port
module multi_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIXED_PRIO = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [LINE_WIDTH-1:0]            mem_wdata,
  input  logic [LINE_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_resp
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t             state, state_nxt;
  arb_op_t                op_q;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  wdata_q;

  logic [NUM_PORTS-1:0]   pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   latch_en;
  logic                   done;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LINE_WIDTH-1:0]  sel_wdata;
  logic                   sel_write;

  rr_picker #(
    .NUM_PORTS  (NUM_PORTS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .req       (req_read | req_write),
    .ptr       (rr_ptr),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // One-hot AND-OR mux of the winner's payload; write wins over read on the same port.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = sel_addr  | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = sel_wdata | req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
        sel_write = sel_write | req_write[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    done      = 1'b0;
    req_resp  = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_BUSY;
          latch_en  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          state_nxt         = ST_IDLE;
          done              = 1'b1;
          req_resp[grant_q] = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    mem_read  = (state == ST_BUSY) && (op_q == OP_READ);
    mem_write = (state == ST_BUSY) && (op_q == OP_WRITE);
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        grant_q <= pick_idx;
        op_q    <= sel_write ? OP_WRITE : OP_READ;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      // Pointer moves past the port just served so it gets lowest priority next time.
      if (done && (FIXED_PRIO == 0)) begin
        if (grant_q == IDX_W'(NUM_PORTS - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_arbiter.sv
// tb/tb_multi_port_arbiter.sv - directed and randomized checks of multi_port_arbiter in both priority modes
module tb_multi_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          use_fx;
  logic [N-1:0]  tb_read, tb_write;
  logic [AW-1:0] tb_addr [N];
  logic [LW-1:0] tb_wdata [N];
  logic [N*AW-1:0] flat_addr;
  logic [N*LW-1:0] flat_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign flat_addr[g*AW +: AW]  = tb_addr[g];
    assign flat_wdata[g*LW +: LW] = tb_wdata[g];
  end

  logic [LW-1:0] rr_req_rdata, fx_req_rdata;
  logic [N-1:0]  rr_req_resp, fx_req_resp;
  logic          rr_mem_read, fx_mem_read, rr_mem_write, fx_mem_write;
  logic [AW-1:0] rr_mem_address, fx_mem_address;
  logic [LW-1:0] rr_mem_wdata, fx_mem_wdata;

  multi_port_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req_read(use_fx ? '0 : tb_read), .req_write(use_fx ? '0 : tb_write),
    .req_addr(flat_addr), .req_wdata(flat_wdata),
    .req_rdata(rr_req_rdata), .req_resp(rr_req_resp),
    .mem_read(rr_mem_read), .mem_write(rr_mem_write),
    .mem_address(rr_mem_address), .mem_wdata(rr_mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(use_fx ? 1'b0 : mem_resp)
  );

  multi_port_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst(rst),
    .req_read(use_fx ? tb_read : '0), .req_write(use_fx ? tb_write : '0),
    .req_addr(flat_addr), .req_wdata(flat_wdata),
    .req_rdata(fx_req_rdata), .req_resp(fx_req_resp),
    .mem_read(fx_mem_read), .mem_write(fx_mem_write),
    .mem_address(fx_mem_address), .mem_wdata(fx_mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(use_fx ? mem_resp : 1'b0)
  );

  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_rdata;
  logic [N-1:0]  m_resp;
  assign m_read  = use_fx ? fx_mem_read    : rr_mem_read;
  assign m_write = use_fx ? fx_mem_write   : rr_mem_write;
  assign m_addr  = use_fx ? fx_mem_address : rr_mem_address;
  assign m_wdata = use_fx ? fx_mem_wdata   : rr_mem_wdata;
  assign m_rdata = use_fx ? fx_req_rdata   : rr_req_rdata;
  assign m_resp  = use_fx ? fx_req_resp    : rr_req_resp;

  int checks   = 0;
  int failures = 0;
  int ptr_rr   = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference choice: fixed mode takes the lowest pending port, round-robin the first pending at or after ptr.
  function automatic int pick(input logic [N-1:0] pend, input bit fixed, input int ptr);
    for (int k = 0; k < N; k++) begin
      int p;
      p = fixed ? k : (ptr + k) % N;
      if (pend[p]) return p;
    end
    return -1;
  endfunction

  // Entered at a negedge with the DUT idle and requests set up; leaves at a negedge after completion.
  task automatic serve(input int w, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                       input int lat, input bit mutate, input logic [LW-1:0] rd);
    chk("gap_read", LW'(m_read), LW'(1'b0));
    chk("gap_write", LW'(m_write), LW'(1'b0));
    @(posedge clk); @(negedge clk);
    chk("grant_read", LW'(m_read), LW'(!wr));
    chk("grant_write", LW'(m_write), LW'(wr));
    chk("grant_addr", LW'(m_addr), LW'(a));
    chk("grant_wdata", m_wdata, d);
    for (int c = 0; c < lat; c++) begin
      if (mutate) begin
        tb_addr[w]  = a ^ 32'h1000;
        tb_wdata[w] = ~d;
      end
      @(posedge clk); @(negedge clk);
      chk("hold_addr", LW'(m_addr), LW'(a));
      chk("hold_wdata", m_wdata, d);
      chk("busy_noresp", LW'(m_resp), LW'(0));
    end
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    chk("resp_onehot", LW'(m_resp), LW'(1) << w);
    chk("resp_rdata", m_rdata, rd);
    @(posedge clk); @(negedge clk);
    mem_resp    = 1'b0;
    tb_read[w]  = 1'b0;
    tb_write[w] = 1'b0;
    if (!use_fx) ptr_rr = (w + 1) % N;
  endtask

  task automatic drain();
    while (|(tb_read | tb_write)) begin
      int w;
      w = pick(tb_read | tb_write, use_fx, ptr_rr);
      serve(w, tb_write[w], tb_addr[w], tb_wdata[w], $urandom_range(0, 3), 1'b0, rand_line());
    end
  endtask

  task automatic random_phase(input int count);
    for (int t = 0; t < count; t++) begin
      int w;
      for (int p = 0; p < N; p++) begin
        if (!(tb_read[p] | tb_write[p]) && ($urandom_range(0, 1) == 1)) begin
          int op;
          op          = $urandom_range(0, 2);
          tb_read[p]  = (op != 1);
          tb_write[p] = (op != 0);
          tb_addr[p]  = $urandom;
          tb_wdata[p] = rand_line();
        end
      end
      if (!(|(tb_read | tb_write))) begin
        mem_resp = 1'b1;
        #1;
        chk("idle_resp_ignored", LW'(m_resp), LW'(0));
        @(posedge clk); @(negedge clk);
        mem_resp = 1'b0;
        chk("idle_stays_idle", LW'(m_read | m_write), LW'(0));
      end else begin
        w = pick(tb_read | tb_write, use_fx, ptr_rr);
        serve(w, tb_write[w], tb_addr[w], tb_wdata[w], $urandom_range(0, 3),
              ($urandom_range(0, 1) == 1), rand_line());
      end
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; use_fx = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    tb_read = '0; tb_write = '0;
    for (int p = 0; p < N; p++) begin tb_addr[p] = '0; tb_wdata[p] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_rr_read", LW'(rr_mem_read), LW'(0));
    chk("rst_rr_write", LW'(rr_mem_write), LW'(0));
    chk("rst_rr_addr", LW'(rr_mem_address), LW'(0));
    chk("rst_rr_resp", LW'(rr_req_resp), LW'(0));
    chk("rst_fx_read", LW'(fx_mem_read | fx_mem_write), LW'(0));
    chk("rst_fx_addr", LW'(fx_mem_address), LW'(0));
    rst = 1'b0;
    @(negedge clk);

    // All four ports requesting continuously: 0,1,2,3,0.
    for (int p = 0; p < N; p++) begin
      tb_read[p] = 1'b1; tb_addr[p] = 32'h1000 + 32'(p * 64); tb_wdata[p] = rand_line();
    end
    for (int s = 0; s < 5; s++) begin
      int ew;
      ew = s % N;
      serve(ew, 1'b0, tb_addr[ew], tb_wdata[ew], 1, 1'b0, rand_line());
      tb_read[ew] = 1'b1;
    end
    drain();

    tb_read[0] = 1'b1; tb_addr[0] = 32'h100;
    serve(0, 1'b0, 32'h100, tb_wdata[0], 1, 1'b0, {32{8'hA5}});

    tb_read[1] = 1'b1; tb_write[1] = 1'b1; tb_addr[1] = 32'h4440; tb_wdata[1] = rand_line();
    serve(1, 1'b1, 32'h4440, tb_wdata[1], 0, 1'b0, rand_line());

    tb_write[2] = 1'b1; tb_addr[2] = 32'h2000; tb_wdata[2] = {16{16'hDEAD}};
    serve(2, 1'b1, 32'h2000, {16{16'hDEAD}}, 2, 1'b1, rand_line());

    // Reset in the middle of a transaction.
    tb_read = '1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_busy", LW'(rr_mem_read), LW'(1));
    rst = 1'b1; mem_resp = 1'b1;
    #1;
    chk("mid_rst_read", LW'(rr_mem_read), LW'(0));
    chk("mid_rst_resp", LW'(rr_req_resp), LW'(0));
    chk("mid_rst_state", LW'(u_rr.state == ST_IDLE), LW'(1));
    chk("mid_rst_ptr", LW'(u_rr.rr_ptr), LW'(0));
    chk("mid_rst_addr", LW'(rr_mem_address), LW'(0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0; mem_resp = 1'b0; ptr_rr = 0;
    drain();

    random_phase(30);

    use_fx = 1'b1;
    @(negedge clk);
    tb_read[1] = 1'b1; tb_read[3] = 1'b1;
    tb_addr[1] = 32'h0111_0000; tb_addr[3] = 32'h0333_0000;
    serve(1, 1'b0, 32'h0111_0000, tb_wdata[1], 1, 1'b0, rand_line());
    serve(3, 1'b0, 32'h0333_0000, tb_wdata[3], 1, 1'b0, rand_line());

    random_phase(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
